// File: rtl/sha3_sponge_ctrl_if.sv
// Message-lane stream into the SHA3 sponge sequencer, with the per-message full_dump select.
interface sha3_sponge_ctrl_if;
  logic [63:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic [1:0]  s_tid;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic        full_dump;

  modport master (
    output s_tdata, s_tkeep, s_tid, s_tlast, s_tvalid, full_dump,
    input  s_tready
  );

  modport slave (
    input  s_tdata, s_tkeep, s_tid, s_tlast, s_tvalid, full_dump,
    output s_tready
  );
endinterface

// File: rtl/sha3_sponge_ctrl.sv
// SHA3 sponge sequencer: absorbs 64-bit lanes, inserts FIPS 202 padding, runs the Keccak core, hands off to the serializer.
// Optional feature: define SHA3_BLK_CNT_EN to build the per-message permutation counter on blk_cnt.
module sha3_sponge_ctrl #(
  parameter int PERM_MAX = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  sha3_sponge_ctrl_if.slave s_axis,
  output logic              st_clr,
  output logic              st_xor_en,
  output logic [4:0]        st_xor_idx,
  output logic [63:0]       st_xor_data,
  output logic              perm_start,
  input  logic              perm_done,
  output logic              out_ready,
  output logic              out_mode,
  output logic [1:0]        out_tid,
  input  logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [15:0]       blk_cnt
);

  // state   | meaning
  // IDLE    | wait for first beat; latch tid/full_dump, clear core
  // ABSORB  | accept lanes, XOR data (plus inline padding) into state
  // PAD     | write padding lanes not covered by the final beat
  // PERM    | permutation running, watchdog armed
  // SQUEEZE | serializer owns the state until out_last
  typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM, SQUEEZE} state_t;

  state_t      state, state_d;
  logic [4:0]  lane_cnt, lane_cnt_d;
  logic [4:0]  pad_idx, pad_idx_d;
  logic        pend06, pend06_d;
  logic        final_q, final_d;
  logic        padnext, padnext_d;
  logic [7:0]  wd_cnt, wd_cnt_d;
  logic        err_d;
  logic        out_mode_d;
  logic [1:0]  out_tid_d;
  logic        st_clr_d;
  logic        st_xor_en_d;
  logic [4:0]  st_xor_idx_d;
  logic [63:0] st_xor_data_d;
  logic        perm_start_d;

  logic [4:0]  last_lane;
  logic        beat;
  logic [3:0]  keep_k;
  logic [5:0]  keep_sh;
  logic [63:0] keep_mask;
  logic [63:0] pad06;

  always_comb begin
    case (out_tid)
      2'd0:    last_lane = 5'd17;
      2'd1:    last_lane = 5'd16;
      2'd2:    last_lane = 5'd12;
      default: last_lane = 5'd8;
    endcase
  end

  assign beat      = s_axis.s_tvalid && s_axis.s_tready;
  assign keep_k    = (s_axis.s_tkeep > 4'd8) ? 4'd8 : s_axis.s_tkeep;
  assign keep_sh   = {keep_k[2:0], 3'b000};
  assign keep_mask = keep_k[3] ? {64{1'b1}} : ((64'h1 << keep_sh) - 64'h1);
  assign pad06     = 64'h06 << keep_sh;

  always_comb begin
    state_d       = state;
    lane_cnt_d    = lane_cnt;
    pad_idx_d     = pad_idx;
    pend06_d      = pend06;
    final_d       = final_q;
    padnext_d     = padnext;
    wd_cnt_d      = wd_cnt;
    err_d         = err;
    out_mode_d    = out_mode;
    out_tid_d     = out_tid;
    st_clr_d      = 1'b0;
    st_xor_en_d   = 1'b0;
    st_xor_idx_d  = 5'd0;
    st_xor_data_d = 64'd0;
    perm_start_d  = 1'b0;

    case (state)
      IDLE: begin
        if (s_axis.s_tvalid) begin
          out_tid_d  = s_axis.s_tid;
          out_mode_d = ~s_axis.full_dump;
          st_clr_d   = 1'b1;
          err_d      = 1'b0;
          lane_cnt_d = 5'd0;
          final_d    = 1'b0;
          padnext_d  = 1'b0;
          state_d    = ABSORB;
        end
      end

      ABSORB: begin
        if (beat) begin
          st_xor_en_d   = 1'b1;
          st_xor_idx_d  = lane_cnt;
          st_xor_data_d = s_axis.s_tdata & keep_mask;
          if (!s_axis.s_tlast) begin
            if (lane_cnt == last_lane) state_d = PERM;
            else                       lane_cnt_d = lane_cnt + 5'd1;
          end else if (!keep_k[3]) begin
            st_xor_data_d = st_xor_data_d | pad06;
            if (lane_cnt == last_lane) begin
              st_xor_data_d = st_xor_data_d | 64'h8000_0000_0000_0000;
              final_d       = 1'b1;
              state_d       = PERM;
            end else begin
              pad_idx_d = last_lane;
              pend06_d  = 1'b0;
              state_d   = PAD;
            end
          end else if (lane_cnt != last_lane) begin
            pad_idx_d = lane_cnt + 5'd1;
            pend06_d  = 1'b1;
            state_d   = PAD;
          end else begin
            // block is full: the 0x06 byte goes into lane 0 of a fresh block
            padnext_d = 1'b1;
            state_d   = PERM;
          end
        end
      end

      PAD: begin
        st_xor_en_d   = 1'b1;
        st_xor_idx_d  = pad_idx;
        st_xor_data_d = (pend06 ? 64'h06 : 64'h0) |
                        ((pad_idx == last_lane) ? 64'h8000_0000_0000_0000 : 64'h0);
        if (pad_idx == last_lane) begin
          final_d = 1'b1;
          state_d = PERM;
        end else begin
          pad_idx_d = last_lane;
          pend06_d  = 1'b0;
        end
      end

      PERM: begin
        // perm_start is high only in the entry cycle, where perm_done is ignored
        if (!perm_start && perm_done) begin
          if (final_q) begin
            state_d = SQUEEZE;
          end else if (padnext) begin
            padnext_d = 1'b0;
            pad_idx_d = 5'd0;
            pend06_d  = 1'b1;
            state_d   = PAD;
          end else begin
            lane_cnt_d = 5'd0;
            state_d    = ABSORB;
          end
        end else if (wd_cnt == 8'd0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt - 8'd1;
        end
      end

      SQUEEZE: begin
        if (out_last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if ((state_d == PERM) && (state != PERM)) begin
      perm_start_d = 1'b1;
      wd_cnt_d     = 8'(PERM_MAX);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state           <= IDLE;
      lane_cnt        <= 5'd0;
      pad_idx         <= 5'd0;
      pend06          <= 1'b0;
      final_q         <= 1'b0;
      padnext         <= 1'b0;
      wd_cnt          <= 8'd0;
      err             <= 1'b0;
      out_mode        <= 1'b0;
      out_tid         <= 2'd0;
      st_clr          <= 1'b0;
      st_xor_en       <= 1'b0;
      st_xor_idx      <= 5'd0;
      st_xor_data     <= 64'd0;
      perm_start      <= 1'b0;
      s_axis.s_tready <= 1'b0;
      out_ready       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      lane_cnt        <= lane_cnt_d;
      pad_idx         <= pad_idx_d;
      pend06          <= pend06_d;
      final_q         <= final_d;
      padnext         <= padnext_d;
      wd_cnt          <= wd_cnt_d;
      err             <= err_d;
      out_mode        <= out_mode_d;
      out_tid         <= out_tid_d;
      st_clr          <= st_clr_d;
      st_xor_en       <= st_xor_en_d;
      st_xor_idx      <= st_xor_idx_d;
      st_xor_data     <= st_xor_data_d;
      perm_start      <= perm_start_d;
      s_axis.s_tready <= (state_d == ABSORB);
      out_ready       <= (state_d == SQUEEZE);
      busy            <= (state_d != IDLE);
    end
  end

`ifdef SHA3_BLK_CNT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                 blk_cnt <= 16'd0;
    else if (st_clr_d)                          blk_cnt <= 16'd0;
    else if (perm_start_d && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
  end
`else
  assign blk_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Randomized bench for sha3_sponge_ctrl: expected lane writes come from a byte-level FIPS 202 padding model.
module tb_sha3_sponge_ctrl;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        st_clr, st_xor_en, perm_start, perm_done, out_ready, out_mode, out_last, busy, err;
  logic [4:0]  st_xor_idx;
  logic [63:0] st_xor_data;
  logic [1:0]  out_tid;
  logic [15:0] blk_cnt;

  sha3_sponge_ctrl_if axis ();

  sha3_sponge_ctrl #(.PERM_MAX(255)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axis(axis),
    .st_clr(st_clr), .st_xor_en(st_xor_en), .st_xor_idx(st_xor_idx), .st_xor_data(st_xor_data),
    .perm_start(perm_start), .perm_done(perm_done),
    .out_ready(out_ready), .out_mode(out_mode), .out_tid(out_tid), .out_last(out_last),
    .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  wire [30:0] ctl_vec = {st_clr, st_xor_en, st_xor_idx, perm_start, out_ready, out_mode,
                         out_tid, busy, err, blk_cnt, axis.s_tready};

  // Monitor: only ever appends; each message check works from a baseline snapshot.
  int          got_blk[$];
  logic [4:0]  got_idx[$];
  logic [63:0] got_dat[$];
  int          n_ps = 0, n_clr = 0, n_sq = 0, sq_bad = 0;
  logic [1:0]  exp_tid;
  logic        exp_mode;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (st_xor_en) begin
        got_blk.push_back(n_ps);
        got_idx.push_back(st_xor_idx);
        got_dat.push_back(st_xor_data);
      end
      if (perm_start) n_ps++;
      if (st_clr) n_clr++;
      if (out_ready) begin
        n_sq++;
        if (out_tid !== exp_tid || out_mode !== exp_mode) sq_bad++;
      end
    end
  end

  // Core model: optional spurious done on the entry cycle, real done 1..6 cycles later.
  bit hold_done = 0;
  initial begin
    perm_done = 1'b0;
    forever begin
      @(negedge ACLK);
      perm_done = 1'b0;
      if (perm_start && !hold_done) begin
        perm_done = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 6)) begin
          @(negedge ACLK);
          perm_done = 1'b0;
        end
        perm_done = 1'b1;
      end
    end
  end

  initial begin
    out_last = 1'b0;
    forever begin
      @(negedge ACLK);
      out_last = 1'b0;
      if (out_ready) begin
        repeat ($urandom_range(0, 4)) @(negedge ACLK);
        out_last = 1'b1;
      end
    end
  end

  byte unsigned cur_msg[$];
  int base_wr, base_ps, base_clr, base_sq, base_bad;

  task automatic send_msg(input logic [1:0] tid, input bit full, input int nbytes);
    int nbeats, k, t;
    logic [63:0] d;
    bit rdy, acc;
    cur_msg.delete();
    for (int i = 0; i < nbytes; i++) cur_msg.push_back(8'($urandom));
    nbeats = (nbytes % 8 != 0 || nbytes == 0) ? nbytes / 8 + 1 : nbytes / 8;
    axis.s_tid = tid;
    axis.full_dump = full;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        axis.s_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge ACLK);
      end
      k = (b == nbeats - 1) ? nbytes - 8 * b : 8;
      d = {$urandom, $urandom};
      for (int j = 0; j < k; j++) d[8*j +: 8] = cur_msg[8*b + j];
      axis.s_tdata  = d;
      axis.s_tkeep  = 4'(k);
      axis.s_tlast  = (b == nbeats - 1);
      axis.s_tvalid = 1'b1;
      acc = 0;
      t = 0;
      while (!acc && t < 300) begin
        rdy = axis.s_tready;
        @(negedge ACLK);
        acc = rdy;
        t++;
      end
      chk("beat_accept", acc, 1);
      if (!acc) break;
      axis.s_tid = 2'($urandom);
      axis.full_dump = 1'($urandom);
    end
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
  endtask

  task automatic check_msg(input logic [1:0] tid);
    int rate, rb, nb, total, t, exp_blk;
    byte unsigned pb [0:511];
    logic [63:0] lane;
    int          e_blk[$];
    logic [4:0]  e_idx[$];
    logic [63:0] e_dat[$];
    rate = (tid == 2'd0) ? 18 : (tid == 2'd1) ? 17 : (tid == 2'd2) ? 13 : 9;
    rb = 8 * rate;
    nb = cur_msg.size();
    total = ((nb + rb) / rb) * rb;
    for (int i = 0; i < 512; i++) pb[i] = 8'h00;
    for (int i = 0; i < nb; i++) pb[i] = cur_msg[i];
    pb[nb] = pb[nb] ^ 8'h06;
    pb[total-1] = pb[total-1] ^ 8'h80;
    // a lane is written iff it carries message bytes, the 0x06 byte, or the final 0x80 byte
    for (int L = 0; L < total / 8; L++) begin
      if (8 * L <= nb || L == total / 8 - 1) begin
        for (int j = 0; j < 8; j++) lane[8*j +: 8] = pb[8*L + j];
        e_blk.push_back(L / rate);
        e_idx.push_back(5'(L % rate));
        e_dat.push_back(lane);
      end
    end
`ifdef SHA3_BLK_CNT_EN
    exp_blk = total / rb;
`else
    exp_blk = 0;
`endif
    t = 0;
    while (!((n_sq > base_sq) && !busy) && t < 4000) begin
      @(negedge ACLK);
      t++;
    end
    chk("msg_done", ((n_sq > base_sq) && !busy), 1);
    chk("n_writes", got_dat.size() - base_wr, e_dat.size());
    for (int i = 0; i < e_dat.size() && base_wr + i < got_dat.size(); i++) begin
      chk("wr_idx", got_idx[base_wr+i], e_idx[i]);
      chk("wr_data", got_dat[base_wr+i], e_dat[i]);
      chk("wr_blk", got_blk[base_wr+i] - base_ps, e_blk[i]);
    end
    chk("n_perm", n_ps - base_ps, total / rb);
    chk("n_clr", n_clr - base_clr, 1);
    chk("sq_tid_mode", sq_bad - base_bad, 0);
    chk("err_clr", err, 0);
    chk("blk_cnt", blk_cnt, exp_blk);
  endtask

  task automatic run_msg(input logic [1:0] tid, input bit full, input int nbytes);
    base_wr  = got_dat.size();
    base_ps  = n_ps;
    base_clr = n_clr;
    base_sq  = n_sq;
    base_bad = sq_bad;
    exp_tid  = tid;
    exp_mode = ~full;
    send_msg(tid, full, nbytes);
    check_msg(tid);
  endtask

  int offs[5] = '{-9, -8, -1, 0, 1};

  initial begin
    int t, rate, nbytes;
    logic [1:0] tid;
    ARESET = 1'b1;
    axis.s_tvalid = 1'b0; axis.s_tlast = 1'b0; axis.s_tdata = '0;
    axis.s_tkeep = '0;    axis.s_tid = '0;    axis.full_dump = 1'b0;
    exp_tid = '0; exp_mode = 1'b1;
    #1;
    chk("rst_ctl", ctl_vec, 0);
    chk("rst_xdata", st_xor_data, 0);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;

    run_msg(2'd1, 1'b0, 0);
    run_msg(2'd3, 1'b0, 72);
    run_msg(2'd0, 1'b1, 139);
    run_msg(2'd2, 1'b0, 112);

    for (int n = 0; n < 14; n++) begin
      tid = 2'($urandom);
      rate = (tid == 2'd0) ? 18 : (tid == 2'd1) ? 17 : (tid == 2'd2) ? 13 : 9;
      if ($urandom_range(0, 1) == 0) nbytes = $urandom_range(0, 300);
      else nbytes = 8 * rate * $urandom_range(1, 2) + offs[$urandom_range(0, 4)];
      run_msg(tid, 1'($urandom), nbytes);
    end

    // watchdog: core never answers
    hold_done = 1;
    send_msg(2'd1, 1'b0, 5);
    t = 0;
    while (!perm_start && t < 50) begin
      @(negedge ACLK);
      t++;
    end
    chk("wd_perm_seen", perm_start, 1);
    repeat (250) @(negedge ACLK);
    chk("wd_early_err", err, 0);
    chk("wd_early_busy", busy, 1);
    repeat (10) @(negedge ACLK);
    chk("wd_err", err, 1);
    chk("wd_idle", busy, 0);
    repeat (5) @(negedge ACLK);
    chk("wd_err_sticky", err, 1);
    hold_done = 0;
    run_msg(2'd0, 1'b0, 40);

    // asynchronous reset while in PAD
    send_msg(2'd1, 1'b0, 8);
    t = 0;
    while (!(st_xor_en && st_xor_idx == 5'd1) && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    chk("pad_seen", (st_xor_en && st_xor_idx == 5'd1), 1);
    #2 ARESET = 1'b1;
    #1;
    chk("arst_ctl", ctl_vec, 0);
    chk("arst_xdata", st_xor_data, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    run_msg(2'd3, 1'b1, 20);
    run_msg(2'($urandom), 1'($urandom), $urandom_range(0, 200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha3_sponge_ctrl.md
# sha3_sponge_ctrl

Sponge sequencer for the SHA3 datapath. It accepts message lanes on an AXI-Stream-style slave and selects the rate from TID (SHA3-224/256/384/512). It XOR-writes data and FIPS 202 padding into the Keccak state one lane at a time and launches the permutation core once per block. After the final permutation it hands the state to the digest serializer and holds that serializer's Ready/Mode/TID until the serializer reports Last.

## Interface
- PERM_MAX, 255: permutation watchdog limit in cycles; 8-bit counter.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- s_tdata  in  64  message lane, byte 0 = bits [7:0].
- s_tkeep  in  4  valid byte count of the beat, 0..8; values other than 8 legal only with s_tlast.
- s_tid  in  2  hash select, sampled on the first beat of a message only: 0=224, 1=256, 2=384, 3=512.
- s_tlast  in  1  final beat of message.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid&&s_tready.
- full_dump  in  1  sampled with s_tid; 1 requests full 1600-bit state output.
- st_clr  out  1  one-cycle pulse: permutation core zeroes its state.
- st_xor_en  out  1  core XORs st_xor_data into lane st_xor_idx.
- st_xor_idx  out  5  lane index, x+5y order.
- st_xor_data  out  64  lane XOR value.
- perm_start  out  1  one-cycle pulse launching a permutation.
- perm_done  in  1  one-cycle pulse from core; ignored outside PERM.
- out_ready  out  1  drives serializer Ready.
- out_mode  out  1  drives serializer Mode; equals ~full_dump latched.
- out_tid  out  2  drives serializer TID; equals latched s_tid.
- out_last  in  1  serializer Last.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog flag; cleared only by ARESET or st_clr.
- blk_cnt  out  16  permutations this message (see Configuration).

## Operation
- Rate R in lanes from latched TID: 0→18, 1→17, 2→13, 3→9.
- IDLE: s_tready=0. When s_tvalid=1: latch s_tid and full_dump, pulse st_clr, clear lane_cnt and blk_cnt, go to ABSORB. The beat is not consumed in IDLE.
- ABSORB: s_tready=1. Each accepted beat writes lane lane_cnt with st_xor_data = s_tdata masked to the low k=s_tkeep bytes.
  - Not last and lane_cnt=R-1: go to PERM.
  - Not last, otherwise: lane_cnt++.
  - Last with k<8: OR 0x06 into byte k of the same write. If lane_cnt=R-1, also OR 0x80 into byte 7 and go to PERM with final=1. Otherwise go to PAD with pad_idx=R-1 and pend06=0.
  - Last with k=8 and lane_cnt<R-1: go to PAD with pad_idx=lane_cnt+1 and pend06=1.
  - Last with k=8 and lane_cnt=R-1: go to PERM with padnext=1.
- PAD: one lane write per cycle. Value = (pend06 ? 0x06 : 0) | (pad_idx=R-1 ? 0x80<<56 : 0).
  - pad_idx=R-1: go to PERM with final=1.
  - Otherwise: set pad_idx=R-1, clear pend06, stay in PAD. At most 2 cycles.
- PERM: perm_start pulses on entry only; blk_cnt increments. On perm_done:
  - final: go to SQUEEZE.
  - padnext: go to PAD with pad_idx=0 and pend06=1.
  - Otherwise: go to ABSORB with lane_cnt=0.
  - No perm_done within PERM_MAX cycles of entry: set err, go to IDLE.
- SQUEEZE: out_ready=1. On out_last=1, out_ready=0 the next cycle and the block returns to IDLE.
- st_xor_en is high only on accepted ABSORB beats and PAD cycles; idx and data are don't-care otherwise but driven to 0.

## Timing
- Reset values: s_tready, st_clr, st_xor_en, st_xor_idx, st_xor_data, perm_start, out_ready, out_mode, out_tid, busy, err, blk_cnt all 0. State = IDLE.
- ARESET mid-message: immediate return to IDLE. In-flight beats and permutation are abandoned; the core is cleared by st_clr of the next message.
- All outputs are registered. st_xor_* and perm_start are asserted the cycle after the triggering condition.
- IDLE→ABSORB takes 1 cycle. Full-lane throughput is 1 beat/cycle. s_tready drops the cycle after the R-th beat.
- perm_done coincident with entry into PERM is ignored; the core's minimum latency is 1 cycle.
- out_tid and out_mode are stable from SQUEEZE entry until IDLE.

## Configuration
- SHA3_BLK_CNT_EN defined: blk_cnt counts perm_start pulses per message, saturating at 0xFFFF, and holds its value in IDLE.
- SHA3_BLK_CNT_EN undefined: blk_cnt is tied to 0 and the counter is not synthesized.

## Test plan
- Empty SHA3-256 message (one beat, tkeep=0, tlast, s_tid=1) → lane 0 XOR 0x06, then lane 16 XOR 0x8000000000000000, one perm_start, out_tid=1, out_mode=1 until out_last.
- SHA3-512, 9 full beats, tlast on the 9th → two permutations. Second block writes lane 0 with 0x06 and lane 8 with 0x80<<56. blk_cnt=2.
- SHA3-224, tlast at lane 17 with tkeep=3 → single write of data|0x06<<24|0x80<<56 to lane 17. final after one permutation.
- SHA3-384, 13 full beats then 1 beat tkeep=8 tlast → PAD writes lane 1 with 0x06, then lane 12 with 0x80<<56. Total perm_start count = 2.
- perm_done held low for 256 cycles in PERM → err=1 and IDLE. Next message's st_clr clears err.
- ARESET asserted during PAD → all outputs 0 asynchronously, busy=0. A new message then restarts cleanly with st_clr.
